// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: redirect input, instruction memory port and decode handshake.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            redirect_i;
  logic [XLEN-1:0] redirect_addr_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [XLEN-1:0] imem_rdata_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] inst_o;
  logic            fetch_fault_o;

  modport master (
    input  redirect_i, redirect_addr_i, imem_rdata_i, inst_ready_i,
    output imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_fault_o
  );

  modport slave (
    output redirect_i, redirect_addr_i, imem_rdata_i, inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_valid_o, pc_o, inst_o, fetch_fault_o
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous buffer of {pc, inst} with clear, push, pop and occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  fetch_entry_t           i_data,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Issue throttling guarantees room for every returning word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_clear && !i_pop && r_count == CNT_FULL));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, throttled imem issue, inflight kill on redirect, output buffer.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises a sticky fault and halts issue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_unit_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] OCC_LIMIT = (CW+1)'(DEPTH);

  logic            r_started;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic [XLEN-1:0] r_fetch_pc;

  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic            w_halt;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  logic [XLEN-1:0] w_target;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;

  assign w_valid  = (w_count != '0);
  assign w_pop    = w_valid & bus.inst_ready_i;
  assign w_target = {bus.redirect_addr_i[XLEN-1:2], 2'b00};

  // Occupancy after this cycle counts the word already on its way back.
  assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
  assign w_issue = r_started & ~w_halt & ~bus.redirect_i & (w_occ < OCC_LIMIT);
  assign w_push  = r_inflight & ~bus.redirect_i;

  assign w_push_data = '{pc: r_inflight_pc, inst: bus.imem_rdata_i};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_started     <= 1'b0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_fetch_pc    <= RESET_PC;
    end else begin
      r_started  <= 1'b1;
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_fetch_pc;
      if (bus.redirect_i)  r_fetch_pc <= w_target;
      else if (w_issue)    r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (bus.redirect_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic            r_fault;
  logic [XLEN-1:0] r_fault_pc;
  logic            w_misalign;

  assign w_misalign = (bus.redirect_addr_i[1:0] != 2'b00);
  assign w_halt     = r_fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (bus.redirect_i) begin
      r_fault <= w_misalign;
      if (w_misalign) r_fault_pc <= bus.redirect_addr_i;
    end
  end

  assign bus.fetch_fault_o = r_fault;
  assign bus.pc_o          = r_fault ? r_fault_pc : w_head.pc;
`else
  assign w_halt            = 1'b0;
  assign bus.fetch_fault_o = 1'b0;
  assign bus.pc_o          = w_head.pc;
`endif

  assign bus.imem_req_o   = w_issue;
  assign bus.imem_addr_o  = r_fetch_pc;
  assign bus.inst_valid_o = w_valid;
  assign bus.inst_o       = w_head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a request-queue reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH  = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } req_t;

  req_t        q[$];
  int          cyc;
  logic [31:0] exp_addr;
  bit          m_fault;
  logic [31:0] m_fault_pc;
  logic        prev_req;
  logic [31:0] prev_addr;
  bit          cur_redir;
  logic [31:0] cur_tgt;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input bit redir, input logic [31:0] tgt, input bit rdy);
    bus.imem_rdata_i    = prev_req ? mem_word(prev_addr) : $urandom();
    bus.redirect_i      = redir;
    bus.redirect_addr_i = tgt;
    bus.inst_ready_i    = rdy;
    cur_redir           = redir;
    cur_tgt             = tgt;
  endtask

  task automatic sample_cycle();
    bit exp_valid, pop, exp_req;
    int occ;
    exp_valid = (q.size() > 0) && (q[0].cyc <= cyc - 2);
    pop       = exp_valid && bus.inst_ready_i;
    check_val("inst_valid", bus.inst_valid_o, exp_valid);
    if (exp_valid) begin
      check_val("pc", bus.pc_o, q[0].pc);
      check_val("inst", bus.inst_o, mem_word(q[0].pc));
    end
    if (m_fault) check_val("fault_pc", bus.pc_o, m_fault_pc);
    occ     = q.size() - (pop ? 1 : 0);
    exp_req = (cyc >= 1) && !m_fault && !cur_redir && (occ < DEPTH);
    check_val("imem_req", bus.imem_req_o, exp_req);
    check_val("imem_addr", bus.imem_addr_o, exp_addr);
    check_val("fault", bus.fetch_fault_o, m_fault);
    prev_req  = bus.imem_req_o;
    prev_addr = bus.imem_addr_o;

    if (pop) void'(q.pop_front());
    if (cur_redir) begin
      q.delete();
      exp_addr = {cur_tgt[31:2], 2'b00};
      if (TRAP) begin
        m_fault = (cur_tgt[1:0] != 2'b00);
        if (m_fault) m_fault_pc = cur_tgt;
      end
    end else if (exp_req) begin
      q.push_back('{pc: exp_addr, cyc: cyc});
      exp_addr = exp_addr + 32'd4;
    end
  endtask

  task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy);
    drive(redir, tgt, rdy);
    @(negedge clk);
    sample_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q.delete();
    m_fault  = 1'b0;
    exp_addr = RST_PC;
    prev_req = 1'b0;
    cyc      = 0;
    drive(1'b0, 32'h0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_val("rst_req", bus.imem_req_o, 1'b0);
      check_val("rst_valid", bus.inst_valid_o, 1'b0);
      check_val("rst_addr", bus.imem_addr_o, RST_PC);
      check_val("rst_pc", bus.pc_o, 32'h0);
      check_val("rst_inst", bus.inst_o, 32'h0);
      check_val("rst_fault", bus.fetch_fault_o, 1'b0);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic random_run(input int n, input int rdy_pct);
    logic [31:0] t;
    bit          r;
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(0, 15) == 0);
      t = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0;
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
      step(r, t, ($urandom_range(0, 99) < rdy_pct));
    end
  endtask

  initial begin
    do_reset();
    repeat (10) step(1'b0, 32'h0, 1'b1);
    repeat (6)  step(1'b0, 32'h0, 1'b0);
    repeat (6)  step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b0);
    repeat (6)  step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0040, 1'b1);
    repeat (6)  step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0102, 1'b1);
    repeat (5)  step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1);
    repeat (6)  step(1'b0, 32'h0, 1'b1);
    random_run(1000, 90);
    random_run(1000, 50);
    do_reset();
    random_run(1000, 25);
    random_run(1000, 100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
